pacman_scan_gen: RTL
====================

PACMAN_SCAN_GEN -- requirements
Module: pacman_scan_gen

Interface
REQ-001 Parameter H_VISIBLE, default 640, active VGA pixels per line.
REQ-002 Parameter H_FRONT / H_SYNC / H_BACK, defaults 16 / 96 / 48, horizontal porch and sync widths in VGA pixels.
REQ-003 Parameter V_VISIBLE, default 480, active VGA lines per frame.
REQ-004 Parameter V_FRONT / V_SYNC / V_BACK, defaults 10 / 2 / 33, vertical porch and sync widths in lines.
REQ-005 Parameter GAME_W / GAME_H, defaults params::pacman::H_VISIBLE_AREA / V_VISIBLE_AREA (224 / 288), game window size.
REQ-006 Parameter H_OFFSET / V_OFFSET, defaults (H_VISIBLE-GAME_W)/2 = 208 and (V_VISIBLE-GAME_H)/2 = 96, window origin in VGA coordinates.
REQ-007 clk  input  1  system clock; the only clock.
REQ-008 rst  input  1  reset, asynchronous, active-high.
REQ-009 pix_stb  input  1  one-clk pulse per VGA pixel period; all counting is gated by it.
REQ-010 hsync  output  1  horizontal sync, active-low.
REQ-011 vsync  output  1  vertical sync, active-low.
REQ-012 vga_de  output  1  high while the VGA raster is inside the 640x480 visible area.
REQ-013 display_enabled  output  1  high while the raster is inside the game window.
REQ-014 sx  output  $clog2(GAME_W)  game-space column, 0..GAME_W-1.
REQ-015 sy  output  $clog2(GAME_H)  game-space row, 0..GAME_H-1.
REQ-016 game_pix_stb  output  1  one-clk pulse per game pixel emitted inside the window.
REQ-017 frame_stb  output  1  one-clk pulse at raster position (0,0).

Function
REQ-018 Internal hcnt counts 0..H_TOTAL-1 (H_TOTAL = sum of horizontal params = 800); it increments only on clk edges with pix_stb=1 and wraps to 0 after H_TOTAL-1.
REQ-019 Internal vcnt counts 0..V_TOTAL-1 (525); it increments only on the pix_stb edge where hcnt wraps, and wraps to 0 after V_TOTAL-1 on that same edge.
REQ-020 All outputs are registered, and they update only on clk edges with pix_stb=1, decoded from the pre-increment (hcnt,vcnt). This gives 1 pix_stb of latency.
REQ-021 hsync is 0 iff hcnt is in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC), i.e. [656,752); otherwise it is 1.
REQ-022 vsync is 0 iff vcnt is in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC), i.e. [490,492); otherwise it is 1.
REQ-023 vga_de is 1 iff hcnt<H_VISIBLE and vcnt<V_VISIBLE.
REQ-024 display_enabled is 1 iff hcnt is in [H_OFFSET, H_OFFSET+GAME_W) and vcnt is in [V_OFFSET, V_OFFSET+GAME_H).
REQ-025 When display_enabled is asserted, sx = hcnt-H_OFFSET and sy = vcnt-V_OFFSET, truncated to port width; outside the window sx and sy are driven to 0.
REQ-026 game_pix_stb is asserted for exactly one clk on each update where display_enabled is set; it is 0 in every clk with pix_stb=0. This gives exactly GAME_W*GAME_H pulses per frame.
REQ-027 frame_stb is asserted for exactly one clk on the update decoded from hcnt=0, vcnt=0; it is 0 otherwise, giving one pulse per frame.
REQ-028 hsync, vsync, vga_de, display_enabled, sx and sy hold their values between pix_stb pulses.
REQ-029 pix_stb asserted on consecutive clks is legal: each assertion advances the raster by one pixel.
REQ-030 Elaboration fails (static assertion) if H_OFFSET+GAME_W > H_VISIBLE or V_OFFSET+GAME_H > V_VISIBLE.

Reset
REQ-031 While rst=1: hcnt=0, vcnt=0, hsync=1, vsync=1, vga_de=0, display_enabled=0, sx=0, sy=0, game_pix_stb=0, frame_stb=0, regardless of clk or pix_stb.
REQ-032 Reset asserted mid-frame takes effect immediately (asynchronously); after deassertion the first pix_stb edge decodes (0,0) and so produces frame_stb=1.

Verification
REQ-033 Release rst, pix_stb every 4th clk -> frame_stb pulse after first pix_stb; next frame_stb exactly 800*525=420000 pix_stb later.
REQ-034 Count over one frame -> game_pix_stb pulses = 64512 (224*288); vga_de-high updates = 307200; hsync-low updates = 96 per line; vsync low for 2 lines (1600 updates).
REQ-035 Raster at hcnt=208,vcnt=96 -> display_enabled=1, sx=0, sy=0, game_pix_stb=1; at hcnt=431,vcnt=383 -> sx=223, sy=287; at hcnt=432 -> display_enabled=0, sx=0.
REQ-036 Hold pix_stb=0 for 100 clks mid-window -> all level outputs frozen, game_pix_stb=0, frame_stb=0 throughout.
REQ-037 Assert rst at hcnt=300,vcnt=200 without clk edge -> outputs at reset values same cycle; after release, first pix_stb -> frame_stb=1.
REQ-038 pix_stb held high continuously -> hcnt wraps 799->0 and vcnt increments on the same edge; at vcnt 524->0 the next update gives frame_stb=1.

Source files
------------

// File: rtl/pacman_scan_gen.sv
// Pacman scan generator.
// A VGA 640x480 raster counter that also produces game-space coordinates
// for a centred GAME_W x GAME_H window. All outputs are registered and
// advance only on pix_stb, decoded from the pre-increment raster position.
module pacman_scan_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  // Native pacman visible area (224 x 288).
  parameter int GAME_W    = 224,
  parameter int GAME_H    = 288,
  parameter int H_OFFSET  = (H_VISIBLE - GAME_W) / 2,
  parameter int V_OFFSET  = (V_VISIBLE - GAME_H) / 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      pix_stb,
  output logic                      hsync,
  output logic                      vsync,
  output logic                      vga_de,
  output logic                      display_enabled,
  output logic [$clog2(GAME_W)-1:0] sx,
  output logic [$clog2(GAME_H)-1:0] sy,
  output logic                      game_pix_stb,
  output logic                      frame_stb
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HC_W    = $clog2(H_TOTAL);
  localparam int VC_W    = $clog2(V_TOTAL);
  localparam int SX_W    = $clog2(GAME_W);
  localparam int SY_W    = $clog2(GAME_H);

  // Boundaries sized to the counters so every compare is width-matched.
  localparam logic [HC_W-1:0] H_LAST   = HC_W'(H_TOTAL - 1);
  localparam logic [HC_W-1:0] H_VIS    = HC_W'(H_VISIBLE);
  localparam logic [HC_W-1:0] HS_BEG   = HC_W'(H_VISIBLE + H_FRONT);
  localparam logic [HC_W-1:0] HS_END   = HC_W'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [HC_W-1:0] HWIN_BEG = HC_W'(H_OFFSET);
  localparam logic [HC_W-1:0] HWIN_END = HC_W'(H_OFFSET + GAME_W);
  localparam logic [VC_W-1:0] V_LAST   = VC_W'(V_TOTAL - 1);
  localparam logic [VC_W-1:0] V_VIS    = VC_W'(V_VISIBLE);
  localparam logic [VC_W-1:0] VS_BEG   = VC_W'(V_VISIBLE + V_FRONT);
  localparam logic [VC_W-1:0] VS_END   = VC_W'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [VC_W-1:0] VWIN_BEG = VC_W'(V_OFFSET);
  localparam logic [VC_W-1:0] VWIN_END = VC_W'(V_OFFSET + GAME_H);

  // The game window must sit entirely inside the visible area.
  if (H_OFFSET + GAME_W > H_VISIBLE) begin : g_bad_hwin
    $error("pacman_scan_gen: game window exceeds visible width");
  end
  if (V_OFFSET + GAME_H > V_VISIBLE) begin : g_bad_vwin
    $error("pacman_scan_gen: game window exceeds visible height");
  end

  logic [HC_W-1:0] hcnt;
  logic [VC_W-1:0] vcnt;
  logic            h_wrap;
  logic            h_win, v_win, win;
  logic [SX_W-1:0] sx_d;
  logic [SY_W-1:0] sy_d;

  // Decode of the current (pre-increment) raster position.
  always_comb begin
    h_wrap = (hcnt == H_LAST);
    h_win  = (hcnt >= HWIN_BEG) && (hcnt < HWIN_END);
    v_win  = (vcnt >= VWIN_BEG) && (vcnt < VWIN_END);
    win    = h_win && v_win;
    sx_d   = '0;
    sy_d   = '0;
    if (win) begin
      sx_d = SX_W'(hcnt - HWIN_BEG);
      sy_d = SY_W'(vcnt - VWIN_BEG);
    end
  end

  // Raster counters; vcnt steps on the same pix_stb edge that wraps hcnt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (pix_stb) begin
      if (h_wrap) begin
        hcnt <= '0;
        vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
      end else begin
        hcnt <= hcnt + 1'b1;
      end
    end
  end

  // Level outputs: refreshed on pix_stb, held otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hsync           <= 1'b1;
      vsync           <= 1'b1;
      vga_de          <= 1'b0;
      display_enabled <= 1'b0;
      sx              <= '0;
      sy              <= '0;
    end else if (pix_stb) begin
      hsync           <= !((hcnt >= HS_BEG) && (hcnt < HS_END));
      vsync           <= !((vcnt >= VS_BEG) && (vcnt < VS_END));
      vga_de          <= (hcnt < H_VIS) && (vcnt < V_VIS);
      display_enabled <= win;
      sx              <= sx_d;
      sy              <= sy_d;
    end
  end

  // Strobes: one clk wide, cleared on every clk without pix_stb.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      game_pix_stb <= 1'b0;
      frame_stb    <= 1'b0;
    end else begin
      game_pix_stb <= pix_stb && win;
      frame_stb    <= pix_stb && (hcnt == '0) && (vcnt == '0);
    end
  end

endmodule
